// File: rtl/clkdiv_sync_ctrl.sv
// Start-up and calibration sequencer for a Gowin CLKDIV: holds RESETN until PLL lock is stable,
// waits for the divider to settle, then issues spaced CALIB pulses; restarts on loss of lock.
module clkdiv_sync_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SETTLE_CYCLES      = 64,
    parameter int CALIB_HIGH_CYCLES  = 2,
    parameter int CALIB_GAP_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       calib_req,
    output logic       calib_ack,
    output logic       clkdiv_resetn,
    output logic       clkdiv_calib,
    output logic       div_ready,
    output logic [7:0] lock_loss_cnt
);

    localparam int LS_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int HI_W  = $clog2(CALIB_HIGH_CYCLES + 1);
    localparam int GAP_W = $clog2(CALIB_GAP_CYCLES + 1);
    localparam int CW_A  = (LS_W > ST_W) ? LS_W : ST_W;
    localparam int CW_B  = (HI_W > GAP_W) ? HI_W : GAP_W;
    localparam int CW    = (CW_A > CW_B) ? CW_A : CW_B;

    localparam logic [CW-1:0] LS_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HI_LAST  = CW'(CALIB_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CALIB_GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] ST_WAIT_LOCK   = 3'd0;
    localparam logic [2:0] ST_LOCK_STABLE = 3'd1;
    localparam logic [2:0] ST_SETTLE      = 3'd2;
    localparam logic [2:0] ST_READY       = 3'd3;
    localparam logic [2:0] ST_CAL_HI      = 3'd4;
    localparam logic [2:0] ST_CAL_GAP     = 3'd5;

    logic          sync1_q;
    logic          sync2_q;
    logic          lock_s;
    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          in_run_s;
    logic          lost_s;
    logic          accept_s;
    logic          seen_ready_q;
    logic          seen_ready_d;
    logic          resetn_q;
    logic          resetn_d;
    logic          ready_q;
    logic          ready_d;
    logic          calib_q;
    logic          calib_d;
    logic          ack_q;
    logic          ack_d;
    logic [7:0]    llc_q;
    logic [7:0]    llc_d;

    // Two-flop resynchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    // Lock loss is only meaningful once the divider has been released
    always_comb begin
        in_run_s = (state_q == ST_SETTLE) || (state_q == ST_READY) ||
                   (state_q == ST_CAL_HI) || (state_q == ST_CAL_GAP);
        lost_s   = in_run_s && !lock_s;
    end

    // Sequencer next-state; lock loss overrides requests and counter expiry
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        if (lost_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_s) begin
                        state_d = ST_LOCK_STABLE;
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_LOCK_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == LS_LAST) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == ST_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (calib_req) begin
                        accept_s = 1'b1;
                        state_d  = ST_CAL_HI;
                        cnt_d    = '0;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_CAL_HI: begin
                    if (cnt_q == HI_LAST) begin
                        state_d = ST_CAL_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_CAL_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output next values; CALIB trails the CAL_HI state by one cycle so the ack cycle stays low
    always_comb begin
        resetn_d     = (state_d == ST_SETTLE) || (state_d == ST_READY) ||
                       (state_d == ST_CAL_HI) || (state_d == ST_CAL_GAP);
        ready_d      = (state_d == ST_READY) || (state_d == ST_CAL_HI) ||
                       (state_d == ST_CAL_GAP);
        calib_d      = (state_q == ST_CAL_HI) && !lost_s;
        ack_d        = accept_s;
        seen_ready_d = seen_ready_q || (state_d == ST_READY);
        if (lost_s && seen_ready_q && (llc_q != 8'hFF)) begin
            llc_d = llc_q + 8'd1;
        end else begin
            llc_d = llc_q;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            seen_ready_q <= 1'b0;
            resetn_q     <= 1'b0;
            ready_q      <= 1'b0;
            calib_q      <= 1'b0;
            ack_q        <= 1'b0;
            llc_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_ready_q <= seen_ready_d;
            resetn_q     <= resetn_d;
            ready_q      <= ready_d;
            calib_q      <= calib_d;
            ack_q        <= ack_d;
            llc_q        <= llc_d;
        end
    end

    assign calib_ack     = ack_q;
    assign clkdiv_resetn = resetn_q;
    assign clkdiv_calib  = calib_q;
    assign div_ready     = ready_q;
    assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_clkdiv_sync_ctrl.sv
// Bench for clkdiv_sync_ctrl (8/4/2/3): directed scenarios plus random traffic against a
// time-since-lock reference model.
module tb_clkdiv_sync_ctrl;

    localparam int N = 8;
    localparam int S = 4;
    localparam int H = 2;
    localparam int G = 3;
    localparam int REL_T = N + 1;
    localparam int RDY_T = N + S + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       calib_req = 1'b0;
    logic       calib_ack;
    logic       clkdiv_resetn;
    logic       clkdiv_calib;
    logic       div_ready;
    logic [7:0] lock_loss_cnt;
    logic [11:0] dut_vec;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: lock samples in flight, run length of synced lock, calib phase
    logic m_s1, m_s2, m_seen, m_ack;
    int   m_t, m_cal, m_llc;

    clkdiv_sync_ctrl #(
        .LOCK_STABLE_CYCLES(N),
        .SETTLE_CYCLES(S),
        .CALIB_HIGH_CYCLES(H),
        .CALIB_GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_lock(pll_lock),
        .calib_req(calib_req),
        .calib_ack(calib_ack),
        .clkdiv_resetn(clkdiv_resetn),
        .clkdiv_calib(clkdiv_calib),
        .div_ready(div_ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    assign dut_vec = {calib_ack, clkdiv_resetn, clkdiv_calib, div_ready, lock_loss_cnt};

    function automatic logic [11:0] exp_vec();
        logic c;
        logic [7:0] l;
        c = (m_cal >= 1) && (m_cal <= H);
        l = m_llc[7:0];
        return {m_ack, (m_t >= REL_T), c, (m_t >= RDY_T), l};
    endfunction

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_seen = 1'b0; m_ack = 1'b0;
        m_t = 0; m_cal = -1; m_llc = 0;
    endtask

    task automatic model_step();
        logic ls;
        ls = m_s2;
        m_ack = 1'b0;
        if (ls) begin
            if ((m_t >= RDY_T) && (m_cal < 0) && calib_req) begin
                m_ack = 1'b1;
                m_cal = 0;
            end else if (m_cal >= 0) begin
                m_cal++;
                if (m_cal == H + G) m_cal = -1;
            end
            if (m_t < RDY_T) m_t++;
            if (m_t >= RDY_T) m_seen = 1'b1;
        end else begin
            if ((m_t >= REL_T) && m_seen && (m_llc < 255)) m_llc++;
            m_t = 0;
            m_cal = -1;
        end
        m_s2 = m_s1;
        m_s1 = pll_lock;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pll_lock = 1'b0; calib_req = 1'b0;
        model_reset();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== 12'h000) begin
            n_fails++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, 12'h000);
        end
    endtask

    task automatic test_cold_start();
        int rise_res, rise_rdy;
        rise_res = -1; rise_rdy = -1;
        pll_lock = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fails++;
                $display("FAIL cold_start cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (rise_res < 0 && clkdiv_resetn === 1'b1) rise_res = i;
            if (rise_rdy < 0 && div_ready === 1'b1) rise_rdy = i;
        end
        n_checks++;
        if (rise_res != 11) begin
            n_fails++;
            $display("FAIL cold_resetn_latency: got %0d expected 11", rise_res);
        end
        n_checks++;
        if (rise_rdy - rise_res != 4) begin
            n_fails++;
            $display("FAIL cold_ready_latency: got %0d expected 4", rise_rdy - rise_res);
        end
    endtask

    task automatic test_lock_glitch();
        int rise_res;
        rise_res = -1;
        do_reset();
        pll_lock = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fails++;
                $display("FAIL lock_glitch cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (rise_res < 0 && clkdiv_resetn === 1'b1) rise_res = i;
            pll_lock = !(i >= 8 && i < 11);
        end
        n_checks++;
        if (rise_res != 22) begin
            n_fails++;
            $display("FAIL glitch_restart: resetn rose at %0d expected 22", rise_res);
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd0) begin
            n_fails++;
            $display("FAIL glitch_llc: got %0d expected 0", lock_loss_cnt);
        end
    endtask

    task automatic test_calibration();
        int acks, highs, first_ack, last_ack;
        acks = 0; highs = 0; first_ack = -1; last_ack = -1;
        n_checks++;
        if (div_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL calib_precondition: div_ready got %b expected 1", div_ready);
        end
        calib_req = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fails++;
                $display("FAIL calibration cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (calib_ack === 1'b1) begin
                if (last_ack >= 0) begin
                    n_checks++;
                    if (i - last_ack != 6) begin
                        n_fails++;
                        $display("FAIL calib_spacing: got %0d expected 6", i - last_ack);
                    end
                end
                if (first_ack < 0) first_ack = i;
                last_ack = i;
                acks++;
            end
            if (clkdiv_calib === 1'b1) highs++;
        end
        calib_req = 1'b0;
        n_checks++;
        if (first_ack != 1 || acks != 3 || highs != 6) begin
            n_fails++;
            $display("FAIL calib_counts: first/acks/highs got %0d/%0d/%0d expected 1/3/6",
                     first_ack, acks, highs);
        end
    endtask

    task automatic test_gap_req();
        int acks, highs;
        acks = 0; highs = 0;
        for (int i = 1; i <= 12; i++) begin
            calib_req = (i == 1) || (i >= 4 && i <= 6);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fails++;
                $display("FAIL gap_req cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (calib_ack === 1'b1) acks++;
            if (clkdiv_calib === 1'b1) highs++;
        end
        calib_req = 1'b0;
        n_checks++;
        if (acks != 1 || highs != 2) begin
            n_fails++;
            $display("FAIL gap_req_counts: acks/highs got %0d/%0d expected 1/2", acks, highs);
        end
    endtask

    task automatic test_lock_loss_cal();
        calib_req = 1'b1;
        pll_lock  = 1'b0;
        tick();
        calib_req = 1'b0;
        tick();
        n_checks++;
        if (clkdiv_calib !== 1'b1) begin
            n_fails++;
            $display("FAIL loss_cal_hi: calib got %b expected 1", clkdiv_calib);
        end
        tick();
        n_checks++;
        if (dut_vec !== 12'h001) begin
            n_fails++;
            $display("FAIL loss_cal_next: got %h expected %h", dut_vec, 12'h001);
        end
        pll_lock = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fails++;
                $display("FAIL loss_resequence cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (div_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL loss_ready_again: got %b expected 1", div_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 1; i <= 1500; i++) begin
            pll_lock = ($urandom_range(0, 99) < 97);
            if (!calib_req) calib_req = ($urandom_range(0, 3) == 0);
            else if (calib_ack) calib_req = ($urandom_range(0, 1) == 0);
            else calib_req = ($urandom_range(0, 9) != 0);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fails++;
                $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        calib_req = 1'b0;
        pll_lock  = 1'b1;
    endtask

    task automatic test_saturation();
        for (int k = 0; k <= 300; k++) begin
            for (int w = 0; w < 60 && ((k == 0) ? div_ready : clkdiv_resetn) !== 1'b1; w++) begin
                tick();
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL saturation loss %0d: got %h expected %h", k, dut_vec, exp_vec());
                end
            end
            n_checks++;
            if (clkdiv_resetn !== 1'b1) begin
                n_fails++;
                $display("FAIL saturation_timeout: loss %0d resetn got %b expected 1", k, clkdiv_resetn);
                break;
            end
            if (k == 300) break;
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            tick();
            tick();
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd255) begin
            n_fails++;
            $display("FAIL llc_saturate: got %0d expected 255", lock_loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        tick();
        n_checks++;
        if (clkdiv_resetn !== 1'b1 || div_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL async_precondition: resetn/ready got %b/%b expected 1/0",
                     clkdiv_resetn, div_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== 12'h000) begin
            n_fails++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, 12'h000);
        end
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fails++;
            $display("FAIL after_async_reset: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cold_start();
        test_lock_glitch();
        test_calibration();
        test_gap_req();
        test_lock_loss_cal();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
